data_memory_unit: RTL

//  Data-memory responder for the single-cycle CPU's load/store port (lwd/lwi/swd/swi).

---
 rtl/data_memory_unit.sv | 110 +++++++++++
 1 files changed

// File: rtl/data_memory_unit.sv
// Data-memory responder for the CPU load/store port. Holds the CPU via busywait_o for a
// fixed latency, then performs the latched load or store.
`timescale 1ns/1ps
module data_memory_unit #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned CNT_WIDTH  = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  read_i,
    input  logic                  write_i,
    input  logic [ADDR_WIDTH-1:0] address_i,
    input  logic [DATA_WIDTH-1:0] writedata_i,
    output logic [DATA_WIDTH-1:0] readdata_o,
    output logic                  busywait_o,
    output logic                  acc_err_o
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CntInit = CNT_WIDTH'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  op_we_q, op_we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  acc_err_q, acc_err_d;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_q [Depth];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_we_d   = op_we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        acc_err_d = 1'b0;
        mem_we    = 1'b0;
        case (state_q)
            StIdle: begin
                if (read_i ^ write_i) begin
                    op_we_d = write_i;
                    addr_d  = address_i;
                    wdata_d = writedata_i;
                    cnt_d   = CntInit;
                    state_d = StBusy;
                end else if (read_i && write_i) begin
                    acc_err_d = 1'b1;
                end
            end
            StBusy: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end else begin
                    if (op_we_q) begin
                        mem_we = 1'b1;
                    end else begin
                        rdata_d = mem_q[addr_q];
                    end
                    state_d = StDone;
                end
            end
            // Requests still held by the CPU are ignored here to avoid a re-trigger.
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            op_we_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            acc_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_we_q   <= op_we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            acc_err_q <= acc_err_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign busywait_o = rst_ni & (((state_q == StIdle) & (read_i ^ write_i)) |
                                  (state_q == StBusy));
    assign readdata_o = rdata_q;
    assign acc_err_o  = acc_err_q;

endmodule
